// File: rtl/wb_sequencer.sv
// wb_sequencer: write-side initiator for a 4-entry register bank.
// Buffers accepted result writes in a small FIFO and issues one bank write per
// cycle, in acceptance order, through the registered WR/rd/data stage.
// Reports whether a queried source register still has a write in flight.
// Optional feature macro: WB_FORWARD_EN (forwards the youngest in-flight value).
module wb_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [ADDR_W-1:0] res_rd,
  input  logic [DATA_W-1:0] res_data,
  input  logic              hold,
  output logic              WR,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] rs_query,
  output logic              pending,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // FIFO storage; entries carry no reset because liveness comes from head/count
  logic [ADDR_W-1:0] mem_rd_q   [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic push;
  logic pop;

  // res_ready comes only from registered count, so there is no path from res_valid
  assign res_ready = (count_q != FULL_CNT);
  assign push      = res_valid & res_ready;
  assign pop       = ~hold & (count_q != '0);

  assign WR   = wr_q;
  assign rd   = rd_q;
  assign data = data_q;

  // Next-state: pointer/count bookkeeping and loading the issue stage from the head
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_d    = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
      wr_d   = 1'b1;
      rd_d   = mem_rd_q[head_q];
      data_d = mem_data_q[head_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and issue-stage registers; reset drops any in-progress write at once
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  // FIFO write port: store the accepted entry at the tail
  always_ff @(posedge clock) begin
    if (push) begin
      mem_rd_q[tail_q]   <= res_rd;
      mem_data_q[tail_q] <= res_data;
    end
  end

  // Per-slot liveness and index match against the queried source register
  logic [DEPTH-1:0] slot_match;
  logic             issue_match;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] age;
    logic             live;
    assign age  = PTR_W'(gi) - head_q;
    assign live = (CNT_W'(age) < count_q);
    assign slot_match[gi] = live & (mem_rd_q[gi] == rs_query);
  end

  assign issue_match = wr_q & (rd_q == rs_query);
  assign pending     = issue_match | (|slot_match);

`ifdef WB_FORWARD_EN
  logic [DATA_W-1:0] fwd_sel;

  // Youngest match wins: issue stage is oldest, then FIFO from head to tail
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot    = head_q;
    fwd_sel = '0;
    if (issue_match) begin
      fwd_sel = data_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q + PTR_W'(k);
      if (slot_match[slot]) begin
        fwd_sel = mem_data_q[slot];
      end
    end
  end

  assign fwd_valid = pending;
  assign fwd_data  = fwd_sel;
`else
  assign fwd_valid = 1'b0;
  assign fwd_data  = '0;
`endif

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Write-side initiator for the 4-entry, 16-bit register bank. Accepts result writes (destination index plus data) from the execute/memory stages through a valid/ready handshake, buffers them in a small FIFO, and drives the bank's write strobe, destination index and write data with one write per cycle, in acceptance order. Also reports whether a queried source register has a write still in flight, and can optionally forward that value.

## Interface
- DATA_W, 16: data width; equals the register bank word.
- ADDR_W, 2: register index width; 4 registers (s0, s1, t0, t1 = 0..3).
- DEPTH, 4: FIFO entries; power of two, at least 2.

- clock  in  1  single clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- res_valid  in  1  producer has a write.
- res_ready  out  1  FIFO can accept; equals not full.
- res_rd  in  ADDR_W  destination index.
- res_data  in  DATA_W  value to write.
- hold  in  1  bank-side stall; suppresses issue.
- WR  out  1  register-bank write strobe.
- rd  out  ADDR_W  register-bank destination index.
- data  out  DATA_W  register-bank write data.
- rs_query  in  ADDR_W  source index being read.
- pending  out  1  some in-flight write targets rs_query.
- fwd_valid  out  1  fwd_data is valid (macro-dependent).
- fwd_data  out  DATA_W  youngest in-flight value for rs_query.

## Operation
- Accept: res_valid & res_ready at a rising edge pushes {res_rd, res_data} at the tail.
- Issue stage: output registers WR/rd/data. At each edge: if hold=0 and FIFO is non-empty, load the head into rd/data, set WR=1 and pop. Otherwise WR=0, and rd/data hold their last values.
- In-flight set: all valid FIFO entries plus the issue stage while WR=1.
- pending: combinational; 1 if any member of the in-flight set has an index equal to rs_query.
- Order is preserved. Two writes to the same index issue in acceptance order, so the last write wins in the bank.
- Push and pop in the same edge: allowed whenever not full, and count is unchanged. When full, res_ready=0, so no push occurs.
- Pointers wrap modulo DEPTH. The count is ADDR-independent, 0..DEPTH inclusive.
- Reset (asserted at any time): count=0, pointers=0, WR=0, rd=0, data=0, res_ready=1, pending=0, fwd_valid=0, fwd_data=0. Queued and issuing writes are discarded; no partial write is emitted.

## Timing
- Accept at edge N into an empty FIFO with hold=0: WR=1 after edge N+1, and the bank commits at edge N+2.
- Throughput: 1 write/cycle sustained, with no bubbles while the FIFO is non-empty and hold=0.
- hold: takes effect at the next edge. WR drops to 0 after that edge, and the head entry stays queued. Issue resumes at the first edge with hold=0.
- res_ready depends only on registered count, with no combinational path from res_valid.
- pending, fwd_valid and fwd_data are combinational from rs_query and the registered state. They are valid the same cycle the bank is read.

## Configuration
- WB_FORWARD_EN defined: fwd_valid = pending. fwd_data is the data of the youngest matching in-flight member. FIFO entries are younger than the issue stage, and the tail side is youngest.
- WB_FORWARD_EN undefined: fwd_valid and fwd_data are tied to 0, and there is no match-priority logic. pending is still produced, and consumers must stall on it.

## Test plan
- Reset then single write: res_rd=2, res_data=16'hBEEF at edge 1 -> WR=1, rd=2, data=BEEF after edge 2. WR=0 after edge 3. Bank t0=BEEF.
- Back-to-back burst: push 5 writes (idx 0,1,2,3,0, data 1..5) with hold=0 -> res_ready stays 1. WR is high for 5 consecutive cycles in order. Bank ends s0=5, s1=2, t0=3, t1=4.
- Full/backpressure: hold=1, push 4 entries -> res_ready=0 after the 4th. A 5th res_valid is not accepted. Release hold -> 4 issues in order, and res_ready=1 after the first pop.
- Hazard/forward: queue writes idx 1 = 16'h0011 then idx 1 = 16'h0022, rs_query=1 -> pending=1. With WB_FORWARD_EN, fwd_valid=1 and fwd_data=0022; without it, fwd_valid=0. rs_query=3 -> pending=0.
- Simultaneous push/pop at count=3: count stays 3, and the issued entry is the head.
- Reset mid-burst: assert resetn=0 with 3 entries queued and WR=1 -> WR=0 immediately, and res_ready=1, pending=0. After release no stale write issues.
